// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bus: command handshake plus pad read-back and open-drain enables.
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] txdata;
  logic       busy;
  logic       done;
  logic       err;
  logic       clkin;
  logic       datain;
  logic       clk_oe;
  logic       dat_oe;

  modport master (
    output start, txdata, clkin, datain,
    input  busy, done, err, clk_oe, dat_oe
  );

  modport slave (
    input  start, txdata, clkin, datain,
    output busy, done, err, clk_oe, dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, 8N-odd frame, ACK check).
// Optional PS2_TX_RETRY_EN: one automatic retry on NAK or timeout before flagging err.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 1200,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned CNT_W          = 18
) (
  input logic         fclk,
  input logic         rst,
  ps2_host_tx_if.slave bus
);
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] PAR_IDX  = IDX_W'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_STOP, S_ACK, S_WAITREL
  } state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [8:0]       sh_q, sh_nxt;
  logic             ok_q, ok_nxt;
  logic             clk_oe_q, clk_oe_nxt;
  logic             dat_oe_q, dat_oe_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             clk_s, dat_s, fall_c, nak_c, tmo_c, may_retry_c;
`ifdef PS2_TX_RETRY_EN
  logic             retry_q, retry_nxt;
`endif

  assign clk_s  = clk_sync_q[1];
  assign dat_s  = dat_sync_q[1];
  assign fall_c = clk_prev_q & ~clk_s;

  // Two-flop synchronizers; idle-high reset values avoid a false fall after reset.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.clkin};
      dat_sync_q <= {dat_sync_q[0], bus.datain};
      clk_prev_q <= clk_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    idx_nxt    = idx_q;
    sh_nxt     = sh_q;
    ok_nxt     = ok_q;
    clk_oe_nxt = clk_oe_q;
    dat_oe_nxt = dat_oe_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    err_nxt    = err_q;
    nak_c      = 1'b0;
    tmo_c      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_nxt   = retry_q;
    may_retry_c = ~retry_q;
`else
    may_retry_c = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        if (bus.start) begin
          sh_nxt     = {~^bus.txdata, bus.txdata};
          err_nxt    = 1'b0;
          busy_nxt   = 1'b1;
          ok_nxt     = 1'b0;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          clk_oe_nxt = 1'b1;
          state_nxt  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_nxt  = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          clk_oe_nxt = 1'b0;
          dat_oe_nxt = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = S_REQ;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_REQ, S_DATA, S_STOP, S_ACK: begin
        // A fall takes priority over a coincident timeout expiry.
        if (fall_c) begin
          cnt_nxt = '0;
          if (state_q == S_REQ) begin
            dat_oe_nxt = ~sh_q[0];
            idx_nxt    = IDX_W'(1);
            state_nxt  = S_DATA;
          end else if (state_q == S_DATA) begin
            dat_oe_nxt = ~sh_q[idx_q];
            if (idx_q == PAR_IDX) state_nxt = S_STOP;
            else                  idx_nxt   = idx_q + IDX_W'(1);
          end else if (state_q == S_STOP) begin
            dat_oe_nxt = 1'b0;
            state_nxt  = S_ACK;
          end else if (!dat_s) begin
            ok_nxt    = 1'b1;
            state_nxt = S_WAITREL;
          end else begin
            nak_c = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          tmo_c = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_WAITREL: begin
        if (clk_s && dat_s) begin
          done_nxt  = ok_q;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Failure handling: optional single restart, otherwise flag err.
    if (nak_c || tmo_c) begin
      if (may_retry_c) begin
        clk_oe_nxt = 1'b1;
        dat_oe_nxt = 1'b0;
        cnt_nxt    = '0;
        state_nxt  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
        retry_nxt  = 1'b1;
`endif
      end else begin
        err_nxt    = 1'b1;
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        ok_nxt     = 1'b0;
        if (tmo_c) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAITREL;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      ok_q     <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      idx_q    <= idx_nxt;
      sh_q     <= sh_nxt;
      ok_q     <= ok_nxt;
      clk_oe_q <= clk_oe_nxt;
      dat_oe_q <= dat_oe_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_nxt;
`endif
    end
  end

  assign bus.clk_oe = clk_oe_q;
  assign bus.dat_oe = dat_oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, PS/2 device model and scoreboard monitor.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int unsigned INH = 40;
  localparam int unsigned TMO = 400;
  localparam int unsigned CW  = 10;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS_ON_ERR = 2;
`else
  localparam int ATTEMPTS_ON_ERR = 1;
`endif
  localparam logic [1:0] K_ACK = 2'd0, K_NAK = 2'd1, K_SILENT = 2'd2, K_ABORT = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] kind;
  } exp_t;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;

  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .fclk(fclk), .rst(rst), .bus(bus)
  );

  // Open-drain pads: either side pulling low wins.
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  assign bus.clkin  = ~(bus.clk_oe | dev_clk_low);
  assign bus.datain = ~(bus.dat_oe | dev_dat_low);

  exp_t exp_q[$];

  // Device model: answers each host request with 11 clock pulses, records the frame.
  logic [1:0]  dev_mode   = K_ACK;
  logic [10:0] dev_frame  = '0;
  int          dev_pulses = 0;
  logic        dev_active = 1'b0;

  initial begin
    int hp;
    forever begin
      @(negedge fclk);
      if (rst && bus.clkin && !bus.datain) begin
        dev_active   = 1'b1;
        dev_pulses   = 0;
        dev_frame    = '0;
        dev_frame[0] = bus.datain;
        if (dev_mode == K_SILENT) begin
          while (!bus.datain) @(negedge fclk);
        end else begin
          hp = int'($urandom_range(30, 15));
          for (int i = 1; i <= 11; i++) begin
            repeat (hp) @(negedge fclk);
            dev_clk_low = 1'b1;
            repeat (hp) @(negedge fclk);
            dev_clk_low = 1'b0;
            if (i <= 10) dev_frame[i] = bus.datain;
            dev_pulses = i;
            if (i == 10 && dev_mode == K_ACK) begin
              repeat (4) @(negedge fclk);
              dev_dat_low = 1'b1;
            end
          end
          repeat (hp) @(negedge fclk);
          dev_dat_low = 1'b0;
        end
        dev_active = 1'b0;
      end
    end
  end

  // Scoreboard monitor state.
  int   total = 0, bad = 0;
  int   inh_run = 0, inh_cnt = 0, inh_snap = 0;
  int   done_cnt = 0, done_snap = 0, since_req = 0;
  logic busy_prev = 1'b0, done_prev = 1'b0, rst_prev = 1'b1;
  int   snap_seq = 0, snap_seen = 0;
  logic [2:0] snap_val = '0;
  logic fin_req = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_end(input exp_t e);
    int par;
    par = ($countones(e.data) % 2 == 0) ? 1 : 0;
    chk("end_clk_oe", int'(bus.clk_oe), 0);
    chk("end_dat_oe", int'(bus.dat_oe), 0);
    case (e.kind)
      K_ACK: begin
        chk("ack_done_pulses", done_cnt - done_snap, 1);
        chk("ack_err", int'(bus.err), 0);
        chk("ack_inhibits", inh_cnt - inh_snap, 1);
      end
      K_NAK: begin
        chk("nak_done_pulses", done_cnt - done_snap, 0);
        chk("nak_err", int'(bus.err), 1);
        chk("nak_inhibits", inh_cnt - inh_snap, ATTEMPTS_ON_ERR);
      end
      K_SILENT: begin
        chk("tmo_done_pulses", done_cnt - done_snap, 0);
        chk("tmo_err", int'(bus.err), 1);
        chk("tmo_inhibits", inh_cnt - inh_snap, ATTEMPTS_ON_ERR);
        chk("tmo_cycles", since_req, int'(TMO));
      end
      default: chk("abort_done_pulses", done_cnt - done_snap, 0);
    endcase
    if (e.kind == K_ACK || e.kind == K_NAK) begin
      chk("frame_start", int'(dev_frame[0]), 0);
      chk("frame_data", int'(dev_frame[8:1]), int'(e.data));
      chk("frame_parity", int'(dev_frame[9]), par);
      chk("frame_stop", int'(dev_frame[10]), 1);
    end
  endtask

  always @(negedge fclk) begin
    exp_t e;
    if (!rst && rst_prev) begin
      chk("reset_clk_oe", int'(bus.clk_oe), 0);
      chk("reset_dat_oe", int'(bus.dat_oe), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_err", int'(bus.err), 0);
    end
    rst_prev = rst;
    if (snap_seq != snap_seen) begin
      snap_seen = snap_seq;
      chk("async_reset_oe_busy", int'(snap_val), 0);
    end
    if (bus.clk_oe) begin
      inh_run++;
    end else if (inh_run != 0) begin
      chk("inhibit_len", inh_run, int'(INH));
      inh_cnt++;
      inh_run   = 0;
      since_req = 0;
    end else begin
      since_req++;
    end
    if (done_prev) chk("done_pulse_width", int'(bus.done), 0);
    done_prev = bus.done;
    if (bus.done) done_cnt++;
    if (bus.busy && !busy_prev) begin
      chk("err_clear_on_start", int'(bus.err), 0);
      done_snap = done_cnt;
      inh_snap  = inh_cnt;
    end
    if (!bus.busy && busy_prev) begin
      chk("expect_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_end(e);
      end
    end
    busy_prev = bus.busy;
    if (fin_req) begin
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Stimulus.
  task automatic issue(input logic [7:0] b, input logic [1:0] kind, input logic [1:0] mode);
    exp_t e;
    e.data = b;
    e.kind = kind;
    exp_q.push_back(e);
    dev_mode = mode;
    @(posedge fclk); #1;
    bus.txdata = b;
    bus.start  = 1'b1;
    @(posedge fclk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_dev_idle();
    int n = 0;
    while (dev_active && n < 5000) begin @(negedge fclk); n++; end
    if (dev_active) begin
      $display("FAIL device_idle: device still active after %0d cycles", n);
      $fatal(1, "device stuck");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 5000) begin @(negedge fclk); n++; end
    if (bus.busy) begin
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", n);
      $fatal(1, "transfer stuck");
    end
    wait_dev_idle();
    repeat (5) @(negedge fclk);
  endtask

  task automatic wait_pulses(input int p);
    int n = 0;
    while (!(dev_active && dev_pulses >= p) && n < 5000) begin @(negedge fclk); n++; end
    if (!(dev_active && dev_pulses >= p)) begin
      $display("FAIL wait_pulses: pulses=%0d required=%0d", dev_pulses, p);
      $fatal(1, "device never clocked");
    end
  endtask

  initial begin
    int r;
    logic [1:0] k;
    bus.start  = 1'b0;
    bus.txdata = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge fclk);
    #1 rst = 1'b1;
    repeat (5) @(posedge fclk);

    issue(8'hED, K_ACK, K_ACK);       wait_idle();
    issue(8'hF4, K_ACK, K_ACK);       wait_idle();
    issue(8'h00, K_NAK, K_NAK);       wait_idle();
    issue(8'h5A, K_ACK, K_ACK);       wait_idle();
    issue(8'hFF, K_SILENT, K_SILENT); wait_idle();
    issue(8'h01, K_ACK, K_ACK);       wait_idle();

    // A second start mid-frame must not disturb the byte in flight.
    issue(8'hA5, K_ACK, K_ACK);
    wait_pulses(3);
    @(posedge fclk); #1;
    bus.txdata = 8'h3C;
    bus.start  = 1'b1;
    @(posedge fclk); #1;
    bus.start  = 1'b0;
    wait_idle();

    // Reset around bit 4 must drop lines and busy without waiting for a clock edge.
    issue(8'h96, K_ABORT, K_ACK);
    wait_pulses(4);
    @(posedge fclk); #2;
    rst = 1'b0;
    #1;
    snap_val = {bus.clk_oe, bus.dat_oe, bus.busy};
    snap_seq++;
    repeat (3) @(posedge fclk); #1;
    rst = 1'b1;
    wait_dev_idle();
    repeat (5) @(negedge fclk);
    issue(8'hED, K_ACK, K_ACK);       wait_idle();

    for (int i = 0; i < 14; i++) begin
      r = int'($urandom_range(9, 0));
      k = (r < 7) ? K_ACK : ((r < 9) ? K_NAK : K_SILENT);
      issue(8'($urandom), k, k);
      wait_idle();
    end

    fin_req = 1'b1;
    repeat (4) @(negedge fclk);
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the write path to the keyboard alongside the existing PS/2 scancode receiver.
- Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the host-request handshake: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then samples the device ACK.
- Drives both lines open-drain through two output-enable signals, for board-level tri-state buffers.

Parameters:
- INHIBIT_CYCLES, 1200, fclk cycles clock is held low before the request (≥100 µs at 11.0592 MHz).
- TIMEOUT_CYCLES, 200000, max fclk cycles between device clock falling edges, or waiting for the first edge, before aborting (~18 ms).
- CNT_W, 18, width of the shared inhibit/timeout counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- fclk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- clkin, input, 1: PS/2 clock line as read back from the pad.
- datain, input, 1: PS/2 data line as read back from the pad.
- start, input, 1: one-cycle pulse; latches txdata and begins a transfer.
- txdata, input, 8: command byte.
- clk_oe, output, 1: 1 = drive PS/2 clock low, 0 = release.
- dat_oe, output, 1: 1 = drive PS/2 data low, 0 = release.
- busy, output, 1: high from the cycle after start until return to IDLE.
- done, output, 1: one-cycle pulse when ACK is received.
- err, output, 1: sticky; set on NAK or timeout, cleared by the next accepted start.

Behaviour:
- Reset: clk_oe=0, dat_oe=0, busy=0, done=0, err=0, state=IDLE, counter=0, bit index=0. Reset asserted mid-transfer releases both lines immediately.
- Input conditioning:
  - clkin and datain pass through two fclk flops.
  - fall = previous synced clock high AND current synced clock low; one-cycle pulse.
  - All data and ACK sampling uses the synced datain.
- Shift register holds txdata plus a parity bit; parity = ~^txdata, so ones(data)+parity is odd.
- States:
  - IDLE: lines released. On start: latch byte and parity, clear err, busy=1, counter=0, go to INHIBIT. start in any other state is ignored.
  - INHIBIT: clk_oe=1, dat_oe=0. When counter reaches INHIBIT_CYCLES-1: set dat_oe=1 (start bit), clear counter, go to REQ.
  - REQ: dat_oe=1, clk_oe=0 (clock released). On first fall: dat_oe=~bit0, index=1, go to DATA.
  - DATA: on each fall, drive the next bit: dat_oe = ~bit[index].
    - Falls 2..8 drive D1..D7.
    - Fall 9 drives parity, then go to STOP.
  - STOP: on fall 10, dat_oe=0 (stop bit = released line), go to ACK.
  - ACK: on fall 11, sample data. 0 → go to WAITREL with success flag. 1 → err=1, go to WAITREL with failure flag.
  - WAITREL: wait until synced clock=1 and data=1. Then pulse done for one cycle if success, busy=0, go to IDLE.
- Timeout:
  - Counter clears on every fall.
  - In REQ, DATA, STOP or ACK, counter reaching TIMEOUT_CYCLES-1 releases both lines, sets err=1, clears busy and goes to IDLE. No done pulse.
- Host output changes occur in the cycle after the detected fall (3 fclk after the pad edge), well inside the device low phase.
- A fall in the same cycle as a timeout expiry: the fall wins.

Optional Feature:
- PS2_TX_RETRY_EN.
- Defined:
  - On NAK or timeout, the first failure restarts from INHIBIT with the same latched byte; busy stays high and err is not set.
  - A second failure sets err and ends the transfer as usual.
  - The retry count resets on each accepted start.
- Undefined: no retry; the first failure sets err.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and ACKs → clk_oe high 1200 cycles; bits sampled on rising clock are 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err=0; busy falls.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0; ACK low → done=1, err=0.
- Device leaves data high at clock 11 (NAK) → err=1, no done, lines released, busy=0; the next start clears err.
- Device never clocks after the request → after 200000 cycles both oe=0, err=1, busy=0; with PS2_TX_RETRY_EN a second INHIBIT phase is observed before err.
- start pulsed during DATA with a different txdata → ignored; the original byte is sent intact.
- rst pulled low at bit 4 → clk_oe=dat_oe=busy=0 asynchronously; after release the module is IDLE and a new start works normally.
